// File: rtl/store_buffer.sv
// Store buffer: formats SB/SH/SW into lane-aligned words, queues them in a small FIFO,
// drains to data memory over req/ack, and flags loads that hit a pending store word.
module store_buffer #(
  parameter int DEPTH     = 4,
  parameter int CPU_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid_i,
  output logic                       st_ready_o,
  input  logic [CPU_WIDTH-1:0]       st_addr_i,
  input  logic [CPU_WIDTH-1:0]       st_data_i,
  input  logic [2:0]                 funct3_i,
  output logic                       exc_o,
  output logic                       mem_wr_req_o,
  input  logic                       mem_wr_ack_i,
  output logic [CPU_WIDTH-1:0]       mem_wr_addr_o,
  output logic [CPU_WIDTH-1:0]       mem_wr_data_o,
  output logic [3:0]                 mem_wr_sel_o,
  input  logic                       ld_chk_i,
  input  logic [CPU_WIDTH-1:0]       ld_addr_i,
  output logic                       ld_hazard_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = CPU_WIDTH - 2;

  logic [WA_W-1:0]      addr_q  [DEPTH];
  logic [CPU_WIDTH-1:0] data_q  [DEPTH];
  logic [3:0]           sel_q   [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [PTR_W-1:0]     head_q;
  logic [PTR_W-1:0]     tail_q;
  logic [CNT_W-1:0]     count_q;
  logic                 exc_q;

  logic                 fmt_ok;
  logic [3:0]           fmt_sel;
  logic [CPU_WIDTH-1:0] fmt_data;
  logic [1:0]           k;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 hit;
  logic                 unused_ld_lsb;

  assign k = st_addr_i[1:0];

  always_comb begin
    fmt_ok   = 1'b0;
    fmt_sel  = 4'b0000;
    fmt_data = '0;
    case (funct3_i)
      3'b000: begin
        fmt_ok   = 1'b1;
        fmt_sel  = 4'b0001 << k;
        fmt_data = {4{st_data_i[7:0]}};
      end
      3'b001: begin
        if (!k[0]) begin
          fmt_ok   = 1'b1;
          fmt_sel  = k[1] ? 4'b1100 : 4'b0011;
          fmt_data = {2{st_data_i[15:0]}};
        end
      end
      3'b010: begin
        if (k == 2'b00) begin
          fmt_ok   = 1'b1;
          fmt_sel  = 4'b1111;
          fmt_data = st_data_i;
        end
      end
      default: ;
    endcase
  end

  // ready looks only at the registered count: no push into a full buffer even while popping
  assign st_ready_o = (count_q < CNT_W'(DEPTH));
  assign accept     = st_valid_i && st_ready_o;
  assign push       = accept && fmt_ok;
  assign pop        = (count_q != '0) && mem_wr_ack_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        sel_q[i]  <= 4'b0000;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      exc_q   <= 1'b0;
    end else begin
      exc_q <= accept && !fmt_ok;
      if (push) begin
        addr_q[tail_q]  <= st_addr_i[CPU_WIDTH-1:2];
        data_q[tail_q]  <= fmt_data;
        sel_q[tail_q]   <= fmt_sel;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // the head entry stays in the compare set until its pop edge
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == ld_addr_i[CPU_WIDTH-1:2])) hit = 1'b1;
    end
  end

  assign unused_ld_lsb = ^ld_addr_i[1:0];

  assign ld_hazard_o   = ld_chk_i && hit;
  assign exc_o         = exc_q;
  assign empty_o       = (count_q == '0);
  assign count_o       = count_q;
  assign mem_wr_req_o  = !empty_o;
  assign mem_wr_addr_o = {addr_q[head_q], 2'b00};
  assign mem_wr_data_o = data_q[head_q];
  assign mem_wr_sel_o  = sel_q[head_q];

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: formatting, exceptions, full/wrap, hazard and async reset.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid_i;
  logic        st_ready_o;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;
  logic [2:0]  funct3_i;
  logic        exc_o;
  logic        mem_wr_req_o;
  logic        mem_wr_ack_i;
  logic [31:0] mem_wr_addr_o;
  logic [31:0] mem_wr_data_o;
  logic [3:0]  mem_wr_sel_o;
  logic        ld_chk_i;
  logic [31:0] ld_addr_i;
  logic        ld_hazard_o;
  logic        empty_o;
  logic [2:0]  count_o;

  int n_chk  = 0;
  int n_pass = 0;

  store_buffer #(.DEPTH(4), .CPU_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .st_valid_i    (st_valid_i),
    .st_ready_o    (st_ready_o),
    .st_addr_i     (st_addr_i),
    .st_data_i     (st_data_i),
    .funct3_i      (funct3_i),
    .exc_o         (exc_o),
    .mem_wr_req_o  (mem_wr_req_o),
    .mem_wr_ack_i  (mem_wr_ack_i),
    .mem_wr_addr_o (mem_wr_addr_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_wr_sel_o  (mem_wr_sel_o),
    .ld_chk_i      (ld_chk_i),
    .ld_addr_i     (ld_addr_i),
    .ld_hazard_o   (ld_hazard_o),
    .empty_o       (empty_o),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    st_valid_i = 1'b1;
    st_addr_i  = a;
    st_data_i  = d;
    funct3_i   = f;
    tick();
    st_valid_i = 1'b0;
  endtask

  task automatic head(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    chk({tag, "_req"},  {31'd0, mem_wr_req_o}, 32'd1);
    chk({tag, "_addr"}, mem_wr_addr_o, a);
    chk({tag, "_data"}, mem_wr_data_o, d);
    chk({tag, "_sel"},  {28'd0, mem_wr_sel_o}, {28'd0, s});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; st_valid_i = 1'b0; st_addr_i = '0; st_data_i = '0; funct3_i = '0;
    mem_wr_ack_i = 1'b0; ld_chk_i = 1'b0; ld_addr_i = '0;
    #12;
    chk("rst_ready",  {31'd0, st_ready_o},   32'd1);
    chk("rst_exc",    {31'd0, exc_o},        32'd0);
    chk("rst_req",    {31'd0, mem_wr_req_o}, 32'd0);
    chk("rst_addr",   mem_wr_addr_o,         32'd0);
    chk("rst_data",   mem_wr_data_o,         32'd0);
    chk("rst_sel",    {28'd0, mem_wr_sel_o}, 32'd0);
    chk("rst_empty",  {31'd0, empty_o},      32'd1);
    chk("rst_count",  {29'd0, count_o},      32'd0);
    chk("rst_hazard", {31'd0, ld_hazard_o},  32'd0);
    rst_n = 1'b1;
    tick();

    // 1: SB with ack held high
    mem_wr_ack_i = 1'b1;
    push(32'h1003, 32'h0000_00A5, 3'b000);
    head("t1", 32'h1000, 32'hA5A5_A5A5, 4'b1000);
    tick();
    chk("t1_empty", {31'd0, empty_o},      32'd1);
    chk("t1_req0",  {31'd0, mem_wr_req_o}, 32'd0);
    mem_wr_ack_i = 1'b0;

    // 2: SH + SW, ack low, then one ack
    push(32'h2002, 32'h0000_BEEF, 3'b001);
    push(32'h2004, 32'h1234_5678, 3'b010);
    chk("t2_count", {29'd0, count_o}, 32'd2);
    head("t2_h0", 32'h2000, 32'hBEEF_BEEF, 4'b1100);
    mem_wr_ack_i = 1'b1; tick(); mem_wr_ack_i = 1'b0;
    head("t2_h1", 32'h2004, 32'h1234_5678, 4'b1111);
    chk("t2_count1", {29'd0, count_o}, 32'd1);
    mem_wr_ack_i = 1'b1; tick(); mem_wr_ack_i = 1'b0;
    chk("t2_empty", {31'd0, empty_o}, 32'd1);

    // 3: misaligned SH and SW, plus illegal funct3
    chk("t3_ready", {31'd0, st_ready_o}, 32'd1);
    push(32'h3001, 32'h1111_2222, 3'b001);
    chk("t3_exc_sh", {31'd0, exc_o}, 32'd1);
    tick();
    chk("t3_exc_lo", {31'd0, exc_o}, 32'd0);
    push(32'h3002, 32'h3333_4444, 3'b010);
    chk("t3_exc_sw", {31'd0, exc_o}, 32'd1);
    push(32'h3000, 32'h5555_6666, 3'b011);
    chk("t3_exc_ill", {31'd0, exc_o}, 32'd1);
    tick();
    chk("t3_exc_end", {31'd0, exc_o},        32'd0);
    chk("t3_count",   {29'd0, count_o},      32'd0);
    chk("t3_req",     {31'd0, mem_wr_req_o}, 32'd0);

    // 4: fill, hold off 5th, one pop, drain order, wrap
    for (int i = 0; i < 4; i++) push(32'h4000 + 4 * i, 32'hA000 + i, 3'b010);
    chk("t4_full_cnt", {29'd0, count_o},    32'd4);
    chk("t4_full_rdy", {31'd0, st_ready_o}, 32'd0);
    st_valid_i = 1'b1; st_addr_i = 32'h4010; st_data_i = 32'hA004; funct3_i = 3'b010;
    tick(); tick();
    chk("t4_held_cnt", {29'd0, count_o}, 32'd4);
    head("t4_held_h", 32'h4000, 32'hA000, 4'b1111);
    mem_wr_ack_i = 1'b1; tick(); mem_wr_ack_i = 1'b0;
    chk("t4_pop_cnt", {29'd0, count_o},    32'd3);
    chk("t4_pop_rdy", {31'd0, st_ready_o}, 32'd1);
    tick();
    st_valid_i = 1'b0;
    chk("t4_refill", {29'd0, count_o}, 32'd4);
    for (int i = 1; i < 5; i++) begin
      head($sformatf("t4_ord%0d", i), 32'h4000 + 4 * i, 32'hA000 + i, 4'b1111);
      mem_wr_ack_i = 1'b1; tick(); mem_wr_ack_i = 1'b0;
    end
    chk("t4_drained", {31'd0, empty_o}, 32'd1);
    push(32'h4100, 32'h4100, 3'b010);
    for (int i = 0; i < 6; i++) begin
      st_valid_i = 1'b1; st_addr_i = 32'h4104 + 4 * i; st_data_i = 32'h4104 + 4 * i;
      funct3_i = 3'b010; mem_wr_ack_i = 1'b1;
      chk($sformatf("t4_wrap_h%0d", i), mem_wr_addr_o, 32'h4100 + 4 * i);
      tick();
      chk($sformatf("t4_wrap_c%0d", i), {29'd0, count_o}, 32'd1);
    end
    st_valid_i = 1'b0;
    head("t4_wrap_last", 32'h4118, 32'h4118, 4'b1111);
    tick();
    mem_wr_ack_i = 1'b0;
    chk("t4_wrap_empty", {31'd0, empty_o}, 32'd1);

    // 5: load hazard
    push(32'h5001, 32'h0000_003C, 3'b000);
    head("t5", 32'h5000, 32'h3C3C_3C3C, 4'b0010);
    ld_chk_i = 1'b1; ld_addr_i = 32'h5003; #1;
    chk("t5_hit", {31'd0, ld_hazard_o}, 32'd1);
    ld_addr_i = 32'h5004; #1;
    chk("t5_miss", {31'd0, ld_hazard_o}, 32'd0);
    ld_chk_i = 1'b0; ld_addr_i = 32'h5003; #1;
    chk("t5_nochk", {31'd0, ld_hazard_o}, 32'd0);
    ld_chk_i = 1'b1; mem_wr_ack_i = 1'b1; #1;
    chk("t5_acking", {31'd0, ld_hazard_o}, 32'd1);
    tick();
    mem_wr_ack_i = 1'b0;
    chk("t5_popped", {31'd0, ld_hazard_o}, 32'd0);
    ld_chk_i = 1'b0;

    // 6: async reset with entries pending
    push(32'h6100, 32'h1, 3'b010);
    push(32'h6104, 32'h2, 3'b010);
    push(32'h6108, 32'h3, 3'b010);
    chk("t6_cnt3", {29'd0, count_o}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req0",   {31'd0, mem_wr_req_o}, 32'd0);
    chk("t6_cnt0",   {29'd0, count_o},      32'd0);
    chk("t6_sel0",   {28'd0, mem_wr_sel_o}, 32'd0);
    mem_wr_ack_i = 1'b1;
    #2 rst_n = 1'b1;
    tick();
    chk("t6_ack_ign", {29'd0, count_o}, 32'd0);
    mem_wr_ack_i = 1'b0;
    push(32'h6000, 32'h0000_0011, 3'b000);
    chk("t6_cnt1", {29'd0, count_o}, 32'd1);
    head("t6_sb", 32'h6000, 32'h1111_1111, 4'b0001);
    mem_wr_ack_i = 1'b1; tick(); mem_wr_ack_i = 1'b0;
    chk("t6_empty", {31'd0, empty_o}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
